// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS datapath.
// Two read ports plus a debug read port, all registered, and two write ports.
// Port B wins over port A on an address collision. A same-cycle write to the
// address being read is forwarded straight into the read register.
// After reset an init sequencer loads every register with its own index and
// only then raises ready.
// Optional feature: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    input  logic [ADDR_WIDTH-1:0] read_address_debug,
    input  logic                  write_enable_a,
    input  logic [ADDR_WIDTH-1:0] write_address_a,
    input  logic [DATA_WIDTH-1:0] write_data_a,
    input  logic                  write_enable_b,
    input  logic [ADDR_WIDTH-1:0] write_address_b,
    input  logic [DATA_WIDTH-1:0] write_data_b,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic [DATA_WIDTH-1:0] data_out_debug,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    // Read ports: 0 = port 1, 1 = port 2, 2 = debug.
    logic [ADDR_WIDTH-1:0]   rd_addr [3];
    logic [DATA_WIDTH-1:0]   rd_d    [3];
    logic [DATA_WIDTH-1:0]   rd_q    [3];

    // Two storage write channels. wr1 is applied after wr0, so it wins.
    // In INIT wr0 carries the init sweep; in RUN wr0 is port A, wr1 port B.
    logic                    wr0_en, wr1_en;
    logic [ADDR_WIDTH-1:0]   wr0_addr, wr1_addr;
    logic [DATA_WIDTH-1:0]   wr0_data, wr1_data;

    assign rd_addr[0] = read_address_1;
    assign rd_addr[1] = read_address_2;
    assign rd_addr[2] = read_address_debug;

    // Sequencer next state and write channel selection.
    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        wr0_en   = 1'b0;
        wr0_addr = '0;
        wr0_data = '0;
        wr1_en   = 1'b0;
        wr1_addr = '0;
        wr1_data = '0;
        if (state_q == ST_INIT) begin
            wr0_en   = 1'b1;
            wr0_addr = ptr_q;
            wr0_data = DATA_WIDTH'(ptr_q);
            ptr_d    = ptr_q + 1'b1;
            if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end else begin
            wr0_en   = write_enable_a && !(ZERO_REG && (write_address_a == '0));
            wr0_addr = write_address_a;
            wr0_data = write_data_a;
            wr1_en   = write_enable_b && !(ZERO_REG && (write_address_b == '0));
            wr1_addr = write_address_b;
            wr1_data = write_data_b;
        end
    end

    // Read data with same-cycle bypass; outputs held at zero during INIT.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_d[p] = '0;
            if (state_q == ST_RUN) begin
                rd_d[p] = regs_q[rd_addr[p]];
                if (wr0_en && (wr0_addr == rd_addr[p])) rd_d[p] = wr0_data;
                if (wr1_en && (wr1_addr == rd_addr[p])) rd_d[p] = wr1_data;
                if (ZERO_REG && (rd_addr[p] == '0))    rd_d[p] = '0;
            end
        end
    end

    // Control state and registered read outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            for (int p = 0; p < 3; p++) rd_q[p] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int p = 0; p < 3; p++) rd_q[p] <= rd_d[p];
        end
    end

    // Storage array, written by the init sweep or by ports A/B.
    // NOTE: the array has no reset; its contents are defined by the init sweep instead.
    always_ff @(posedge clock) begin
        if (wr0_en) regs_q[wr0_addr] <= wr0_data;
        if (wr1_en) regs_q[wr1_addr] <= wr1_data;
    end

    assign data_out_1     = rd_q[0];
    assign data_out_2     = rd_q[1];
    assign data_out_debug = rd_q[2];
    assign ready          = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (32 x 32).
// Expected values assume every register holds its index after init.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [DW-1:0] R0_A = 32'h0;
    localparam logic [DW-1:0] R0_B = 32'h0;
`else
    localparam logic [DW-1:0] R0_A = 32'h1234;
    localparam logic [DW-1:0] R0_B = 32'h55;
`endif

    typedef struct {
        logic [AW-1:0] ra1, ra2, rad;
        logic          wea;
        logic [AW-1:0] waa;
        logic [DW-1:0] wda;
        logic          web;
        logic [AW-1:0] wab;
        logic [DW-1:0] wdb;
        logic [DW-1:0] exp1, exp2, expd;
    } vec_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] read_address_1, read_address_2, read_address_debug;
    logic          write_enable_a, write_enable_b;
    logic [AW-1:0] write_address_a, write_address_b;
    logic [DW-1:0] write_data_a, write_data_b;
    logic [DW-1:0] data_out_1, data_out_2, data_out_debug;
    logic          ready;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t main_tbl [11];
    vec_t post_tbl [3];

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock              (clock),
        .reset              (reset),
        .read_address_1     (read_address_1),
        .read_address_2     (read_address_2),
        .read_address_debug (read_address_debug),
        .write_enable_a     (write_enable_a),
        .write_address_a    (write_address_a),
        .write_data_a       (write_data_a),
        .write_enable_b     (write_enable_b),
        .write_address_b    (write_address_b),
        .write_data_b       (write_data_b),
        .data_out_1         (data_out_1),
        .data_out_2         (data_out_2),
        .data_out_debug     (data_out_debug),
        .ready              (ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [AW-1:0] ra1, ra2, rad,
                                input logic wea, input logic [AW-1:0] waa, input logic [DW-1:0] wda,
                                input logic web, input logic [AW-1:0] wab, input logic [DW-1:0] wdb,
                                input logic [DW-1:0] e1, e2, ed);
        vec_t v;
        v.ra1 = ra1; v.ra2 = ra2; v.rad = rad;
        v.wea = wea; v.waa = waa; v.wda = wda;
        v.web = web; v.wab = wab; v.wdb = wdb;
        v.exp1 = e1; v.exp2 = e2; v.expd = ed;
        return v;
    endfunction

    task automatic idle_inputs();
        write_enable_a = 1'b0; write_address_a = '0; write_data_a = '0;
        write_enable_b = 1'b0; write_address_b = '0; write_data_b = '0;
        read_address_1 = '0; read_address_2 = '0; read_address_debug = '0;
    endtask

    // Drive one vector, clock it in, compare all three read ports.
    task automatic apply(input string tag, input vec_t v);
        read_address_1 = v.ra1; read_address_2 = v.ra2; read_address_debug = v.rad;
        write_enable_a = v.wea; write_address_a = v.waa; write_data_a = v.wda;
        write_enable_b = v.web; write_address_b = v.wab; write_data_b = v.wdb;
        @(posedge clock);
        #1;
        check({tag, ".out1"}, data_out_1, v.exp1);
        check({tag, ".out2"}, data_out_2, v.exp2);
        check({tag, ".outd"}, data_out_debug, v.expd);
        idle_inputs();
    endtask

    // Walk the init sweep: ready low for DEPTH-1 edges, high on edge DEPTH.
    // An attempted port A write of 0xFF to address 3 is held throughout.
    task automatic init_sweep(input string tag);
        write_enable_a = 1'b1; write_address_a = 5'd3; write_data_a = 32'hFF;
        read_address_1 = 5'd7;
        for (int n = 1; n <= DEPTH; n++) begin
            @(posedge clock);
            #1;
            check($sformatf("%s.ready@%0d", tag, n), DW'(ready), (n == DEPTH) ? 32'd1 : 32'd0);
            if (n == DEPTH / 2) check({tag, ".out1_init"}, data_out_1, 32'd0);
        end
        idle_inputs();
    endtask

    initial begin
        main_tbl[0]  = mk(5'd7,  5'd31, 5'd2,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'd7,        32'd31,       32'd2);
        main_tbl[1]  = mk(5'd5,  5'd6,  5'd5,  1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,    32'hDEADBEEF, 32'd6,        32'hDEADBEEF);
        main_tbl[2]  = mk(5'd5,  5'd31, 5'd1,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'hDEADBEEF, 32'd31,       32'd1);
        main_tbl[3]  = mk(5'd9,  5'd9,  5'd8,  1, 5'd9,  32'h11,       1, 5'd9,  32'h22,   32'h22,       32'h22,       32'd8);
        main_tbl[4]  = mk(5'd9,  5'd9,  5'd9,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'h22,       32'h22,       32'h22);
        main_tbl[5]  = mk(5'd12, 5'd13, 5'd14, 1, 5'd13, 32'hBBBB,     1, 5'd12, 32'hAAAA, 32'hAAAA,     32'hBBBB,     32'd14);
        main_tbl[6]  = mk(5'd12, 5'd13, 5'd12, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'hAAAA,     32'hBBBB,     32'hAAAA);
        main_tbl[7]  = mk(5'd0,  5'd0,  5'd3,  1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,    R0_A,         R0_A,         32'd3);
        main_tbl[8]  = mk(5'd0,  5'd0,  5'd0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    R0_A,         R0_A,         R0_A);
        main_tbl[9]  = mk(5'd0,  5'd20, 5'd0,  1, 5'd0,  32'h66,       1, 5'd0,  32'h55,   R0_B,         32'd20,       R0_B);
        main_tbl[10] = mk(5'd0,  5'd9,  5'd5,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    R0_B,         32'h22,       32'hDEADBEEF);

        post_tbl[0]  = mk(5'd10, 5'd3,  5'd5,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'd10,       32'd3,        32'd5);
        post_tbl[1]  = mk(5'd9,  5'd12, 5'd31, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'd9,        32'd12,       32'd31);
        post_tbl[2]  = mk(5'd0,  5'd1,  5'd30, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,    32'd0,        32'd1,        32'd30);

        idle_inputs();
        reset = 1'b1;
        #3;
        check("rst.out1", data_out_1, 32'd0);
        check("rst.out2", data_out_2, 32'd0);
        check("rst.outd", data_out_debug, 32'd0);
        check("rst.ready", DW'(ready), 32'd0);
        #19 reset = 1'b0;

        init_sweep("init1");
        for (int i = 0; i < 11; i++) apply($sformatf("main%0d", i), main_tbl[i]);

        // Reset in RUN with non-zero outputs: everything clears asynchronously.
        read_address_1 = 5'd7;
        read_address_debug = 5'd31;
        @(posedge clock);
        #1;
        check("pre_rst.out1", data_out_1, 32'd7);
        #1 reset = 1'b1;
        #1;
        check("run_rst.out1", data_out_1, 32'd0);
        check("run_rst.outd", data_out_debug, 32'd0);
        check("run_rst.ready", DW'(ready), 32'd0);
        #2 reset = 1'b0;
        idle_inputs();

        // Reset again after 10 init writes; the sweep restarts from zero.
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("init_rst.out1", data_out_1, 32'd0);
        check("init_rst.ready", DW'(ready), 32'd0);
        #2 reset = 1'b0;

        init_sweep("init2");
        for (int i = 0; i < 3; i++) apply($sformatf("post%0d", i), post_tbl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
